dsc_mul_seq: RTL and testbench

- Sequencer for the 4-input, 8-bit deterministic stochastic-computing multiplier datapath (chained SNGs, AND gate, stoch2bin counter).
- Accepts an operand set over a valid/ready handshake and holds the operands stable on the datapath.
- Clears the datapath, enables it until its overflow/early-shutoff flag or a cycle watchdog fires, then captures the binary product.
- Returns the product with status over a second valid/ready handshake. Sits between the host/bus interface and the multiplier datapath.

---
 rtl/dsc_mul_seq.sv | 171 +++++++++++++++++
 tb/tb_dsc_mul_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_seq.sv
// Sequencer for the deterministic stochastic-computing multiplier datapath:
// accepts operands, clears/enables the datapath, captures the product and returns it with status.
module dsc_mul_seq #(
    parameter int                   SNG_WIDTH  = 8,
    parameter int                   NUM_INPUTS = 4,
    parameter int                   CNT_WIDTH  = 32,
    parameter logic [CNT_WIDTH-1:0] MAX_CYCLES = 32'hFFFF_FFFF,
    parameter int                   CLR_CYCLES = 2,
    parameter int                   MIN_RUN    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SNG_WIDTH-1:0]            a,
    input  logic [SNG_WIDTH-1:0]            b,
    input  logic [SNG_WIDTH-1:0]            c,
    input  logic [SNG_WIDTH-1:0]            d,
    input  logic                            abort,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0] out_z,
    output logic [CNT_WIDTH-1:0]            out_cycles,
    output logic                            out_timeout,
    output logic                            out_zero,
    output logic                            busy,
    output logic                            dp_rst,
    output logic                            dp_en,
    output logic [SNG_WIDTH-1:0]            dp_a,
    output logic [SNG_WIDTH-1:0]            dp_b,
    output logic [SNG_WIDTH-1:0]            dp_c,
    output logic [SNG_WIDTH-1:0]            dp_d,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0] dp_z,
    input  logic                            dp_ov
);

    localparam int ZW    = NUM_INPUTS * SNG_WIDTH;
    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = MAX_CYCLES - CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MIN  = CNT_WIDTH'(MIN_RUN);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_CAPTURE, S_DONE} state_t;

    state_t                 state_q;
    logic [CLR_W-1:0]       clr_cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [SNG_WIDTH-1:0]   dp_a_q, dp_b_q, dp_c_q, dp_d_q;
    logic [ZW-1:0]          out_z_q;
    logic [CNT_WIDTH-1:0]   out_cycles_q;
    logic                   out_timeout_q, out_zero_q, out_valid_q;
    logic                   busy_q, dp_rst_q, dp_en_q;
    logic                   any_zero;

    // The run counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign any_zero = (a == '0) || (b == '0) || (c == '0) || (d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            clr_cnt_q     <= '0;
            cnt_q         <= '0;
            dp_a_q        <= '0;
            dp_b_q        <= '0;
            dp_c_q        <= '0;
            dp_d_q        <= '0;
            out_z_q       <= '0;
            out_cycles_q  <= '0;
            out_timeout_q <= 1'b0;
            out_zero_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            dp_rst_q      <= 1'b1;
            dp_en_q       <= 1'b0;
        end else if (abort && (state_q == S_CLEAR || state_q == S_RUN || state_q == S_CAPTURE)) begin
            // Cancel: one-cycle datapath reset pulse, no result is ever presented.
            state_q  <= S_IDLE;
            dp_en_q  <= 1'b0;
            dp_rst_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dp_en_q  <= 1'b0;
                    dp_rst_q <= 1'b0;
                    if (in_valid && in_ready) begin
                        dp_a_q <= a;
                        dp_b_q <= b;
                        dp_c_q <= c;
                        dp_d_q <= d;
                        busy_q <= 1'b1;
                        out_z_q       <= '0;
                        out_cycles_q  <= '0;
                        out_timeout_q <= 1'b0;
                        if (any_zero) begin
                            state_q     <= S_DONE;
                            out_zero_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= S_CLEAR;
                            out_zero_q <= 1'b0;
                            clr_cnt_q  <= '0;
                            cnt_q      <= '0;
                            dp_rst_q   <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q  <= S_RUN;
                        dp_rst_q <= 1'b0;
                        dp_en_q  <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    cnt_q <= sat_inc(cnt_q);
                    // Overflow beats the watchdog when both fire in the same cycle.
                    if (dp_ov && (cnt_q >= CNT_MIN)) begin
                        state_q       <= S_CAPTURE;
                        dp_en_q       <= 1'b0;
                        out_timeout_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= S_CAPTURE;
                        dp_en_q       <= 1'b0;
                        out_timeout_q <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    out_z_q      <= dp_z;
                    out_cycles_q <= cnt_q;
                    out_valid_q  <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    dp_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_z       = out_z_q;
    assign out_cycles  = out_cycles_q;
    assign out_timeout = out_timeout_q;
    assign out_zero    = out_zero_q;
    assign busy        = busy_q;
    assign dp_rst      = dp_rst_q;
    assign dp_en       = dp_en_q;
    assign dp_a        = dp_a_q;
    assign dp_b        = dp_b_q;
    assign dp_c        = dp_c_q;
    assign dp_d        = dp_d_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Scoreboard bench for dsc_mul_seq: a behavioural datapath stub drives dp_ov/dp_z,
// expected results are queued on accept and checked by an independent monitor.
module tb_dsc_mul_seq;

    localparam int SW   = 8;
    localparam int NI   = 4;
    localparam int CW   = 32;
    localparam int MAXC = 16;
    localparam int CLRC = 2;
    localparam int MINR = 1;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, abort, out_valid, out_ready;
    logic [SW-1:0] a, b, c, d, dp_a, dp_b, dp_c, dp_d;
    logic [NI*SW-1:0] out_z, dp_z;
    logic [CW-1:0] out_cycles;
    logic          out_timeout, out_zero, busy, dp_rst, dp_en, dp_ov;

    dsc_mul_seq #(
        .SNG_WIDTH(SW), .NUM_INPUTS(NI), .CNT_WIDTH(CW),
        .MAX_CYCLES(32'(MAXC)), .CLR_CYCLES(CLRC), .MIN_RUN(MINR)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .out_cycles(out_cycles), .out_timeout(out_timeout), .out_zero(out_zero),
        .busy(busy), .dp_rst(dp_rst), .dp_en(dp_en),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_z(dp_z), .dp_ov(dp_ov)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        int          cycles;
        bit          timeout;
        bit          zero;
        logic [7:0]  oa, ob, oc, od;
        int          bp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   en_seen = 0;
    int   rst_seen = 0;
    int   cfg_ov_first = 1000;
    bit   cfg_glitch = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Datapath stub: overflow is asserted from RUN count ov_first onward, plus an optional count-0 glitch.
    always @(negedge clk) begin
        dp_ov = (en_seen >= cfg_ov_first) || (cfg_glitch && en_seen == 0);
        if (dp_en === 1'b1) en_seen++;
        if (dp_rst === 1'b1) rst_seen++;
    end

    // Reference: first RUN count k where overflow is seen and k >= MIN_RUN ends the run (k+1 cycles);
    // otherwise the watchdog ends it after MAX_CYCLES cycles.
    function automatic void model_run(input int ov_first, input bit glitch, output int n, output bit to);
        n  = MAXC;
        to = 1'b1;
        for (int k = 0; k < MAXC; k++) begin
            if (((k >= ov_first) || (glitch && k == 0)) && k >= MINR) begin
                n  = k + 1;
                to = 1'b0;
                return;
            end
        end
    endfunction

    task automatic issue(input logic [7:0] ia, ib, ic, id, input int ov_first, input bit glitch,
                         input logic [31:0] z, input int bp, input bit push);
        int   w;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a = ia; b = ib; c = ic; d = id;
        w = 0;
        while (in_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: in_ready stuck at %b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        cfg_ov_first = ov_first;
        cfg_glitch   = glitch;
        dp_z         = z;
        en_seen      = 0;
        rst_seen     = 0;
        if (push) begin
            e.oa = ia; e.ob = ib; e.oc = ic; e.od = id; e.bp = bp;
            e.zero = (ia == 0) || (ib == 0) || (ic == 0) || (id == 0);
            if (e.zero) begin
                e.z = '0; e.cycles = 0; e.timeout = 1'b0;
            end else begin
                e.z = z;
                model_run(ov_first, glitch, e.cycles, e.timeout);
            end
            q.push_back(e);
        end
    endtask

    task automatic wait_run(input int n);
        int w = 0;
        while (en_seen != n && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("reach_run_cycle", 64'(en_seen), 64'(n));
    endtask

    // Monitor: pops the oldest expectation whenever a result is presented.
    initial begin
        exp_t        e;
        logic [31:0] snap;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got 1 required 0");
                end else begin
                    e = q.pop_front();
                    check("out_z", 64'(out_z), 64'(e.z));
                    check("out_cycles", 64'(out_cycles), 64'(e.cycles));
                    check("out_timeout", 64'(out_timeout), 64'(e.timeout));
                    check("out_zero", 64'(out_zero), 64'(e.zero));
                    check("dp_operands", {32'd0, dp_a, dp_b, dp_c, dp_d}, {32'd0, e.oa, e.ob, e.oc, e.od});
                    check("dp_en_cycles", 64'(en_seen), 64'(e.cycles));
                    check("dp_rst_cycles", 64'(rst_seen), 64'(e.zero ? 0 : CLRC));
                    check("done_busy_ready", {busy, in_ready}, 64'b10);
                    snap = out_z;
                    for (int i = 0; i < e.bp; i++) begin
                        @(negedge clk);
                        check("hold_stable", {out_valid, in_ready, out_z == snap, dp_a == e.oa}, 64'b1011);
                    end
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                check("release_valid", 64'(out_valid), 64'd0);
            end
        end
    end

    initial begin
        int w;
        logic [7:0] r[4];
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0;
        a = '0; b = '0; c = '0; d = '0; dp_z = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_dp_rst", 64'(dp_rst), 64'd1);
        check("rst_outs", {out_valid, busy, dp_en, out_timeout, out_zero}, 64'd0);
        check("rst_data", {dp_a, dp_b, dp_c, dp_d, out_z}, 64'd0);
        check("rst_cycles", 64'(out_cycles), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_dp_rst", 64'(dp_rst), 64'd0);

        // Directed cases: zero shortcut, normal, watchdog, ov at watchdog edge, MIN_RUN guard.
        issue(8'h00, 8'hFF, 8'hFF, 8'hFF, 1000, 1'b0, 32'hDEAD_BEEF, 0, 1'b1);
        issue(8'd3, 8'd5, 8'd7, 8'd9, 5, 1'b0, 32'd17, 0, 1'b1);
        issue(8'd1, 8'd1, 8'd1, 8'd1, 1000, 1'b0, 32'd99, 2, 1'b1);
        issue(8'd2, 8'd2, 8'd2, 8'd2, 15, 1'b0, 32'd55, 0, 1'b1);
        issue(8'd4, 8'd4, 8'd4, 8'd4, 3, 1'b1, 32'd7, 0, 1'b1);
        issue(8'd5, 8'd6, 8'd7, 8'd8, 1000, 1'b1, 32'd8, 0, 1'b1);
        // Backpressure; the next issue holds in_valid high while the result waits.
        issue(8'd9, 8'd8, 8'd7, 8'd6, 2, 1'b0, 32'd1234, 10, 1'b1);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 1, 1'b0, 32'd5, 0, 1'b1);

        // Abort mid-RUN.
        issue(8'd11, 8'd12, 8'd13, 8'd14, 1000, 1'b0, 32'd77, 0, 1'b0);
        wait_run(3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_dp_rst", 64'(dp_rst), 64'd1);
        check("abort_state", {in_ready, busy, dp_en, out_valid}, 64'b1000);
        check("abort_en_cycles", 64'(en_seen), 64'd4);
        @(posedge clk);
        #1;
        check("abort_dp_rst_pulse", 64'(dp_rst), 64'd0);

        // rst mid-RUN.
        issue(8'd21, 8'd22, 8'd23, 8'd24, 1000, 1'b0, 32'd88, 0, 1'b0);
        wait_run(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_ctrl", {in_ready, dp_rst, busy, dp_en, out_valid}, 64'b11000);
        check("midrst_ops", {dp_a, dp_b, dp_c, dp_d}, 64'd0);

        // Randomized operations.
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 4; k++) r[k] = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 4) == 0) r[$urandom_range(0, 3)] = 8'd0;
            issue(r[0], r[1], r[2], r[3], int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                  32'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        w = 0;
        while ((q.size() != 0 || out_valid !== 1'b0) && w < 500) begin
            @(posedge clk);
            w++;
        end
        check("drain_pending", 64'(q.size()), 64'd0);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
